// File: rtl/cpu1_key_pio_n_if.sv
// Avalon-MM slave bus for the key PIO: register access plus the interrupt line.
interface cpu1_key_pio_n_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/cpu1_key_pio_n.sv
// Debounced key input PIO: two-flop synchroniser, per-channel debounce, edge
// capture with write-1-to-clear, interrupt mask and a registered Avalon-MM read port.
module cpu1_key_pio_n #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EDGE_TYPE       = 1,
   parameter int IRQ_TYPE        = 1,
   parameter int INIT_LEVEL      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   cpu1_key_pio_n_if.slave  bus
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{1'(INIT_LEVEL)}};
   localparam logic [31:0]      CFG      = {20'b0, 1'(IRQ_TYPE), 1'b0, 2'(EDGE_TYPE), 8'(WIDTH)};

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_edge_cap;
   logic [WIDTH-1:0] r_irq_mask;
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [31:0]      r_readdata;

   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_accept;
   logic [WIDTH-1:0] w_set;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic [31:0]      w_rd_next;
   logic             w_unused_wd;

   assign w_wr        = bus.chipselect & ~bus.write_n;
   assign w_diff      = r_sync2 ^ r_stable;
   assign w_unused_wd = ^bus.writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= INIT_VEC;
         r_sync2 <= INIT_VEC;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

   // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
   always_comb begin
      w_accept = '0;
      w_set    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
      end
      if (EDGE_TYPE == 0) begin
         w_set = w_accept & r_sync2 & ~r_stable;
      end else if (EDGE_TYPE == 1) begin
         w_set = w_accept & ~r_sync2 & r_stable;
      end else begin
         w_set = w_accept;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stable <= INIT_VEC;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!w_diff[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_cnt[i]    <= '0;
               r_stable[i] <= r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_clr = (w_wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;

   // A new edge on the same cycle as a clearing write must survive, so set is ORed last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_edge_cap <= '0;
         r_irq_mask <= '0;
      end else begin
         r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
         if (w_wr && bus.address == 3'd2) begin
            r_irq_mask <= bus.writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      w_rd_next = '0;
      case (bus.address)
         3'd0:    w_rd_next = 32'(r_stable);
         3'd1:    w_rd_next = 32'(r_sync2);
         3'd2:    w_rd_next = 32'(r_irq_mask);
         3'd3:    w_rd_next = 32'(r_edge_cap);
         3'd4:    w_rd_next = CFG;
         default: w_rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_next;
      end
   end

   assign bus.readdata = r_readdata;
   // Keys are active-low, so in level mode a pressed (low) key raises the request.
   assign bus.irq = (IRQ_TYPE == 0) ? |(~r_stable & r_irq_mask)
                                    : |(r_edge_cap & r_irq_mask);

endmodule
